// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: byte width and the
// sequencer state encoding used by uart_tx_fifo.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock byte FIFO with wrap-bit pointers.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (pointers and flags only)
//   wr_en_i     push request; dropped when full, which sets overflow_o
//   wr_data_i   byte to enqueue
//   rd_en_i     pop request; ignored when empty
//   rd_data_o   byte at the head (combinational view of the storage)
//   full_o      DEPTH bytes held
//   empty_o     no bytes held
//   level_o     occupancy, wr_ptr - rd_ptr
//   overflow_o  sticky: a push was dropped
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic [BYTE_W-1:0]       wr_data_i,
  input  logic                    rd_en_i,
  output logic [BYTE_W-1:0]       rd_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              push, pop;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];

  // Equal index bits with differing wrap bits means the writer has lapped
  // the reader exactly once.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rd_idx];

  // full/empty are pre-edge values, so a push while full is dropped even
  // when a pop retires an entry on the same edge.
  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push)              wr_ptr_d   = wr_ptr_q + PW'(1);
    if (pop)               rd_ptr_d   = rd_ptr_q + PW'(1);
    if (wr_en_i && full_o) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO plus transmit sequencer in front of uart_tx. Bytes are issued
// one at a time with a one-cycle tx_start pulse; a byte leaves the FIFO only
// once the transmitter acknowledges it by raising tx_busy.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   wr_en     push wr_data this cycle
//   wr_data   byte to enqueue
//   full      FIFO holds DEPTH bytes
//   empty     FIFO holds 0 bytes
//   level     current occupancy
//   overflow  sticky: a push was dropped
//   tx_start  one-cycle start pulse to uart_tx
//   tx_data   byte presented to uart_tx (held until the next issue)
//   tx_busy   busy flag from uart_tx
//
// Build option:
//   UART_TX_FIFO_TIMEOUT_EN  when defined, the sequencer gives up waiting
//                            for tx_busy after RESP_TIMEOUT cycles and
//                            re-issues the same byte; otherwise it waits
//                            indefinitely.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy
);

  seq_state_e        state_q;
  logic              tx_start_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [BYTE_W-1:0] head_data;
  logic              pop;

`ifdef UART_TX_FIFO_TIMEOUT_EN
  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          to_expire;
  assign to_expire = (to_cnt_q == CW'(RESP_TIMEOUT - 1));
`endif

  // The head entry is retired on the first RESP cycle that sees tx_busy,
  // including the case where tx_busy was already high on entry.
  assign pop = (state_q == S_RESP) && tx_busy;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (head_data),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef UART_TX_FIFO_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= head_data;
            state_q    <= S_RESP;
`ifdef UART_TX_FIFO_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end
        end
        S_RESP: begin
          tx_start_q <= 1'b0;
          if (tx_busy) begin
            state_q <= S_DONE;
          end
`ifdef UART_TX_FIFO_TIMEOUT_EN
          // No acknowledge: go back without popping so the head is re-issued.
          else if (to_expire) begin
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + CW'(1);
          end
`endif
        end
        S_DONE: begin
          if (!tx_busy) state_q <= S_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int RTO   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .RESP_TIMEOUT(RTO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] sb[$];          // bytes expected at the transmitter, in order
  int         n_push = 0;     // accepted pushes
  int         n_pop = 0;      // acknowledged (popped) bytes
  int         n_pulses = 0;
  int         cyc = 0;
  int         last_start_cyc = -100;
  int         last_gap = 0;
  bit         prev_start = 1'b0;
  bit         lvl_chk_en = 1'b0;
  bit         silent_all = 1'b0;
  int         silent_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  // Transmitter model: busy rises 2 cycles after the pulse, held 10 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_start && !silent_all) begin
        if (silent_left > 0) begin
          silent_left--;
        end else begin
          @(posedge clk);
          @(posedge clk);
          #1 tx_busy = 1'b1;
          @(posedge clk);
          #1;
          n_pop++;
          if (sb.size() > 0) void'(sb.pop_front());
          repeat (9) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: every start pulse must carry the byte at the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && tx_start) begin
        n_pulses++;
        chk("start_one_cycle", {31'b0, prev_start}, 32'd0);
        last_gap = cyc - last_start_cyc;
        chk("start_gap_ge3", {31'b0, (last_gap >= 3)}, 32'd1);
        last_start_cyc = cyc;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_start: data 0x%0h with nothing queued", tx_data);
        end else begin
          chk("tx_data", {24'b0, tx_data}, {24'b0, sb[0]});
        end
      end
      prev_start = tx_start;
    end
  end

  // Level tracker, active during the wrap test.
  initial begin
    forever begin
      @(negedge clk);
      if (lvl_chk_en) chk("level_track", {27'b0, level}, n_push - n_pop);
    end
  end

  task automatic push(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (acc) begin
      sb.push_back(b);
      n_push++;
    end
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    wr_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_tx_data",  {24'b0, tx_data},  32'd0);
    chk("rst_empty",    {31'b0, empty},    32'd1);
    chk("rst_full",     {31'b0, full},     32'd0);
    chk("rst_level",    {27'b0, level},    32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (empty && !tx_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int maxc, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (n_pulses >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(nm);
  endtask

  initial begin
    string msg;
    int    p0;
    bit    ok;
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Single byte, level drops on the tx_busy cycle
    do_reset();
    p0 = n_pulses;
    push(8'h48, 1'b1);
    chk("t1_empty_after_push", {31'b0, empty}, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("t1_wait_busy");
    chk("t1_level_at_busy", {27'b0, level}, 32'd1);
    @(negedge clk);
    #1;
    chk("t1_level_after_pop", {27'b0, level}, 32'd0);
    wait_idle(200, "t1_drain");
    chk("t1_pulse_count", n_pulses - p0, 32'd1);

    // 15-byte message back-to-back
    msg = "Hello, world!\n\r";
    p0 = n_pulses;
    for (int i = 0; i < msg.len(); i++) push(msg[i], 1'b1);
    wait_idle(2000, "t2_drain");
    chk("t2_pulse_count", n_pulses - p0, 32'd15);
    chk("t2_overflow",    {31'b0, overflow}, 32'd0);
    chk("t2_empty",       {31'b0, empty},    32'd1);

    // Fill with a silent transmitter, then overflow
    do_reset();
    silent_all = 1'b1;
    for (int i = 0; i < 15; i++) push(8'hC0 + 8'(i), 1'b1);
    chk("t3_not_full_at_15", {31'b0, full}, 32'd0);
    push(8'hCF, 1'b1);
    chk("t3_full_at_16",     {31'b0, full},     32'd1);
    chk("t3_no_ovf_at_16",   {31'b0, overflow}, 32'd0);
    push(8'hEE, 1'b0);
    chk("t3_overflow",       {31'b0, overflow}, 32'd1);
    chk("t3_level",          {27'b0, level},    32'd16);
    chk("t3_full_after_17",  {31'b0, full},     32'd1);
    silent_all = 1'b0;

    // Drain 4, then 20 across the pointer wrap with per-cycle level tracking
    do_reset();
    n_push = 0;
    n_pop  = 0;
    lvl_chk_en = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b1);
    wait_idle(500, "t4_drain_first");
    for (int i = 0; i < 20; i++) begin
      ok = 1'b0;
      for (int w = 0; w < 500; w++) begin
        if (!full) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      if (!ok) timeout_fail("t4_wait_not_full");
      push(8'h80 + 8'(i), 1'b1);
    end
    wait_idle(3000, "t4_drain_wrap");
    lvl_chk_en = 1'b0;
    chk("t4_overflow", {31'b0, overflow}, 32'd0);
    chk("t4_all_out",  n_push - n_pop,    32'd0);

    // Reset while in DONE with 3 bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (tx_busy && level == 5'd3) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("t5_reach_done");
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_level",    {27'b0, level},    32'd0);
    chk("t5_tx_start", {31'b0, tx_start}, 32'd0);
    chk("t5_empty",    {31'b0, empty},    32'd1);
    chk("t5_state",    32'(dut.state_q),  32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pulses;
    repeat (30) @(negedge clk);
    #1;
    chk("t5_no_pulses", n_pulses - p0, 32'd0);
    push(8'h55, 1'b1);
    wait_idle(200, "t5_new_byte");
    chk("t5_new_pulse", n_pulses - p0, 32'd1);

`ifdef UART_TX_FIFO_TIMEOUT_EN
    // Silent first request: same byte re-issued after RESP_TIMEOUT
    do_reset();
    silent_left = 1;
    p0 = n_pulses;
    push(8'hA5, 1'b1);
    wait_pulses(p0 + 1, 50, "t6_first_pulse");
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_pop_before_ack", {27'b0, level}, 32'd1);
    wait_pulses(p0 + 2, 100, "t6_second_pulse");
    chk("t6_retry_gap",       last_gap,        RTO + 1);
    chk("t6_level_at_retry",  {27'b0, level},  32'd1);
    wait_idle(200, "t6_drain");
    chk("t6_pulse_count", n_pulses - p0,    32'd2);
    chk("t6_empty",       {31'b0, empty},   32'd1);
`endif

    chk("final_scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
